// File: rtl/replica_pkg.sv
// Shared replica types plus the or-opt sequencer state encoding and LFSR constants.
package replica_pkg;

    localparam int city_num  = 32;
    localparam int OPT_IDX_W = 7;

    typedef enum logic [1:0] {
        CMD_NOP  = 2'd0,
        CMD_INIT = 2'd1,
        CMD_OPT  = 2'd2,
        CMD_OUT  = 2'd3
    } replica_command_t;

    typedef enum logic {
        OPT_THR = 1'b0,
        OPT_OR0 = 1'b1
    } opt_command_t;

    typedef struct packed {
        opt_command_t         command;
        logic [OPT_IDX_W-1:0] K;
        logic [OPT_IDX_W-1:0] L;
    } opt_t;

    typedef enum logic [2:0] {
        SEQ_IDLE   = 3'd0,
        SEQ_DRAW   = 3'd1,
        SEQ_ISSUE  = 3'd2,
        SEQ_SWEEP  = 3'd3,
        SEQ_DECIDE = 3'd4,
        SEQ_FIN    = 3'd5
    } opt_seq_state_t;

    localparam logic [15:0] LFSR_TAPS  = 16'hB400;
    localparam logic [15:0] LFSR_RESET = 16'hACE1;

    // One right-shifting Galois step.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/opt_lfsr.sv
// 16-bit Galois LFSR that advances two steps per enabled cycle; seed load wins over stepping.
module opt_lfsr
    import replica_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        step,
    output logic [15:0] state
);

    // state register: reset value, seed load, or double step
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LFSR_RESET;
        end else if (load) begin
            state <= seed;
        end else if (step) begin
            state <= lfsr_next(lfsr_next(state));
        end
    end

endmodule

// File: rtl/opt_sequencer.sv
// opt_sequencer: draws an or-opt move (K,L), issues one route sweep, waits for the
// Metropolis verdict, and repeats for a programmed number of trials.
// Optional build macro OPT_STATS_EN adds accept/reject/THR-draw counters.
//
// state  | meaning
// IDLE   | waiting for start_i
// DRAW   | drawing K then L from the LFSR, rejecting out-of-range values
// ISSUE  | command pulse cycle towards opt_route
// SWEEP  | opt_route is walking the route; count 1..CITY_NUM-1
// DECIDE | waiting for accept_v_i
// FIN    | done_o pulse, back to IDLE
module opt_sequencer
    import replica_pkg::*;
#(
    parameter int CITY_NUM = city_num,
    parameter int IDX_W    = 7,
    parameter int ITER_W   = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_i,
    input  logic [ITER_W-1:0]   iter_i,
    input  replica_command_t    run_cmd_i,
    input  logic [15:0]         seed_i,
    output replica_command_t    command_o,
    output opt_t                opt_o,
    output logic                decide_o,
    input  logic                accept_v_i,
    input  logic                accept_i,
    output logic                commit_o,
    output logic                busy_o,
    output logic                done_o
`ifdef OPT_STATS_EN
    ,
    output logic [ITER_W-1:0]   acc_cnt_o,
    output logic [ITER_W-1:0]   rej_cnt_o,
    output logic [ITER_W-1:0]   thr_cnt_o
`endif
);

    localparam logic [IDX_W-1:0] CITY_MAX = IDX_W'(CITY_NUM - 1);

    opt_seq_state_t    state;
    logic [ITER_W-1:0] remaining;
    replica_command_t  run_cmd;
    logic [IDX_W-1:0]  k_q;
    logic              have_k;
    logic [IDX_W-1:0]  sweep_cnt;
    logic [15:0]       lfsr_q;
    logic [IDX_W-1:0]  r;
    logic              r_valid;
    logic              start_ok;
    logic              unused_lfsr;

    assign start_ok    = (state == SEQ_IDLE) && start_i;
    assign r           = lfsr_q[IDX_W-1:0];
    assign r_valid     = (r != '0) && (r <= CITY_MAX);
    assign unused_lfsr = ^lfsr_q[15:IDX_W];

    opt_lfsr u_lfsr (
        .clk   (clk),
        .reset (reset),
        .load  (start_ok && (seed_i != 16'h0000)),
        .seed  (seed_i),
        .step  (state == SEQ_DRAW),
        .state (lfsr_q)
    );

    // sequencing FSM with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= SEQ_IDLE;
            command_o     <= CMD_NOP;
            opt_o.command <= OPT_THR;
            opt_o.K       <= '0;
            opt_o.L       <= '0;
            decide_o      <= 1'b0;
            commit_o      <= 1'b0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            remaining     <= '0;
            run_cmd       <= CMD_NOP;
            k_q           <= '0;
            have_k        <= 1'b0;
            sweep_cnt     <= '0;
        end else begin
            commit_o <= 1'b0;
            done_o   <= 1'b0;
            case (state)
                SEQ_IDLE: begin
                    if (start_i) begin
                        remaining <= iter_i;
                        run_cmd   <= run_cmd_i;
                        have_k    <= 1'b0;
                        if (iter_i == '0) begin
                            state  <= SEQ_FIN;
                            done_o <= 1'b1;
                        end else begin
                            state  <= SEQ_DRAW;
                            busy_o <= 1'b1;
                        end
                    end
                end
                SEQ_DRAW: begin
                    if (r_valid) begin
                        if (!have_k) begin
                            k_q    <= r;
                            have_k <= 1'b1;
                        end else begin
                            opt_o.command <= (k_q == r) ? OPT_THR : OPT_OR0;
                            opt_o.K       <= (r < k_q) ? r : k_q;
                            opt_o.L       <= (r < k_q) ? k_q : r;
                            command_o     <= run_cmd;
                            state         <= SEQ_ISSUE;
                        end
                    end
                end
                SEQ_ISSUE: begin
                    command_o <= CMD_NOP;
                    sweep_cnt <= IDX_W'(1);
                    state     <= SEQ_SWEEP;
                end
                SEQ_SWEEP: begin
                    if (sweep_cnt == CITY_MAX) begin
                        sweep_cnt <= '0;
                        decide_o  <= 1'b1;
                        state     <= SEQ_DECIDE;
                    end else begin
                        sweep_cnt <= sweep_cnt + IDX_W'(1);
                    end
                end
                SEQ_DECIDE: begin
                    if (accept_v_i) begin
                        decide_o <= 1'b0;
                        commit_o <= accept_i;
                        if (remaining != '0) begin
                            remaining <= remaining - ITER_W'(1);
                        end
                        if (remaining <= ITER_W'(1)) begin
                            state  <= SEQ_FIN;
                            done_o <= 1'b1;
                            busy_o <= 1'b0;
                        end else begin
                            state  <= SEQ_DRAW;
                            have_k <= 1'b0;
                        end
                    end
                end
                SEQ_FIN: begin
                    state <= SEQ_IDLE;
                end
                default: begin
                    state <= SEQ_IDLE;
                end
            endcase
        end
    end

`ifdef OPT_STATS_EN
    // saturating verdict and THR-draw counters, cleared when a batch starts
    always_ff @(posedge clk) begin
        if (reset || start_ok) begin
            acc_cnt_o <= '0;
            rej_cnt_o <= '0;
            thr_cnt_o <= '0;
        end else begin
            if (state == SEQ_DECIDE && accept_v_i) begin
                if (accept_i && acc_cnt_o != '1) begin
                    acc_cnt_o <= acc_cnt_o + ITER_W'(1);
                end
                if (!accept_i && rej_cnt_o != '1) begin
                    rej_cnt_o <= rej_cnt_o + ITER_W'(1);
                end
            end
            if (state == SEQ_DRAW && r_valid && have_k && r == k_q && thr_cnt_o != '1) begin
                thr_cnt_o <= thr_cnt_o + ITER_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_opt_sequencer.sv
// Testbench for opt_sequencer: table of batches, randomized batches, forced-THR draw and
// mid-sweep reset, all checked against a trial-level model of the draw/sweep/verdict rules.
module tb_opt_sequencer;
    import replica_pkg::*;

    localparam int CITY_NUM = city_num;

    logic             clk;
    logic             reset;
    logic             start_i;
    logic [15:0]      iter_i;
    replica_command_t run_cmd_i;
    logic [15:0]      seed_i;
    replica_command_t command_o;
    opt_t             opt_o;
    logic             decide_o;
    logic             accept_v_i;
    logic             accept_i;
    logic             commit_o;
    logic             busy_o;
    logic             done_o;

    opt_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start_i    (start_i),
        .iter_i     (iter_i),
        .run_cmd_i  (run_cmd_i),
        .seed_i     (seed_i),
        .command_o  (command_o),
        .opt_o      (opt_o),
        .decide_o   (decide_o),
        .accept_v_i (accept_v_i),
        .accept_i   (accept_i),
        .commit_o   (commit_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [15:0] m_lfsr;

    typedef struct packed {
        logic [15:0] lfsr_after;
        logic [6:0]  k;
        logic [6:0]  l;
        logic [15:0] cyc;
        logic [15:0] n_zero;
        logic [15:0] n_big;
    } draw_t;

    typedef struct packed {
        logic [15:0]      iter;
        logic [15:0]      seed;
        replica_command_t cmd;
        logic [31:0]      verd;
        logic [15:0]      exp_pulses;
        logic [15:0]      exp_commits;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] m_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    // Draw cycles: each cycle looks at the low 7 bits, then advances two steps.
    function automatic draw_t model_draw(input logic [15:0] s0);
        draw_t d;
        logic [15:0] s;
        int got;
        int first;
        int r;
        s = s0;
        d = '0;
        got = 0;
        first = 0;
        for (int n = 0; n < 4000 && got < 2; n++) begin
            r = int'(s[6:0]);
            s = m_step(m_step(s));
            d.cyc = d.cyc + 16'd1;
            if (r == 0) d.n_zero = d.n_zero + 16'd1;
            else if (r >= CITY_NUM) d.n_big = d.n_big + 16'd1;
            else begin
                if (got == 0) first = r;
                else begin
                    d.k = 7'((first < r) ? first : r);
                    d.l = 7'((first < r) ? r : first);
                end
                got++;
            end
        end
        d.lfsr_after = s;
        return d;
    endfunction

    task automatic run_batch(input int iter, input logic [15:0] seed, input replica_command_t cmd,
                             input logic [31:0] verd, output int pulses, output int commits);
        draw_t d;
        opt_t  exp_opt;
        int    cyc;
        bit    ok;
        int    hold;
        pulses  = 0;
        commits = 0;
        start_i   = 1'b1;
        iter_i    = 16'(iter);
        seed_i    = seed;
        run_cmd_i = cmd;
        tick();
        start_i   = 1'b0;
        iter_i    = 16'($urandom);
        seed_i    = 16'($urandom);
        run_cmd_i = CMD_NOP;
        if (seed != 16'h0) m_lfsr = seed;
        if (iter == 0) begin
            chk("iter0_done", done_o, 1);
            chk("iter0_busy", busy_o, 0);
            chk("iter0_cmd", command_o, CMD_NOP);
            tick();
            chk("iter0_done_len", done_o, 0);
            return;
        end
        chk("busy_after_start", busy_o, 1);
        for (int t = 0; t < iter; t++) begin
            d = model_draw(m_lfsr);
            m_lfsr = d.lfsr_after;
            exp_opt.command = (d.k == d.l) ? OPT_THR : OPT_OR0;
            exp_opt.K = d.k;
            exp_opt.L = d.l;
            cyc = 0;
            while (command_o == CMD_NOP && cyc < 400) begin
                tick();
                cyc++;
            end
            chk("draw_cycles", cyc, d.cyc);
            chk("cmd_value", command_o, cmd);
            if (command_o != CMD_NOP) pulses++;
            chk("opt_value", opt_o, exp_opt);
            ok = 1'b1;
            for (int k = 1; k <= CITY_NUM; k++) begin
                accept_v_i = 1'($urandom);
                accept_i   = 1'($urandom);
                start_i    = (k == 5);
                seed_i     = 16'($urandom);
                iter_i     = 16'($urandom_range(0, 1));
                run_cmd_i  = CMD_INIT;
                tick();
                if (k < CITY_NUM && decide_o) ok = 1'b0;
                if (command_o != CMD_NOP || opt_o != exp_opt || commit_o || done_o || !busy_o) ok = 1'b0;
            end
            accept_v_i = 1'b0;
            start_i    = 1'b0;
            chk("decide_latency", decide_o, 1);
            chk("sweep_quiet", ok, 1);
            hold = $urandom_range(0, 2);
            ok = 1'b1;
            for (int h = 0; h < hold; h++) begin
                tick();
                if (!decide_o || commit_o) ok = 1'b0;
            end
            if (hold > 0) chk("decide_hold", ok, 1);
            accept_v_i = 1'b1;
            accept_i   = verd[t];
            tick();
            accept_v_i = 1'b0;
            accept_i   = 1'b0;
            chk("commit", commit_o, verd[t]);
            if (commit_o) commits++;
            chk("decide_clear", decide_o, 0);
            chk("done_at_end", done_o, (t == iter - 1));
            chk("busy_at_end", busy_o, (t != iter - 1));
        end
        tick();
        chk("done_len", done_o, 0);
        chk("idle_busy", busy_o, 0);
        chk("idle_commit", commit_o, 0);
    endtask

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    vec_t vecs[$];
    int pulses;
    int commits;
    int cyc;
    logic [15:0] fseed;
    bit found;
    draw_t fd;

    initial begin
        reset = 1'b1; start_i = 1'b0; iter_i = '0; run_cmd_i = CMD_NOP; seed_i = '0;
        accept_v_i = 1'b0; accept_i = 1'b0;
        tick(); tick(); tick();
        reset = 1'b0;
        m_lfsr = 16'hACE1;
        for (int i = 0; i < 10; i++) tick();
        chk("reset_cmd", command_o, CMD_NOP);
        chk("reset_opt", opt_o, {OPT_THR, 7'd0, 7'd0});
        chk("reset_busy", busy_o, 0);
        chk("reset_flags", {decide_o, commit_o, done_o}, 3'b000);

        vecs.push_back('{16'd1, 16'h1234, CMD_OPT,  32'b1,   16'd1, 16'd1});
        vecs.push_back('{16'd3, 16'hBEEF, CMD_INIT, 32'b101, 16'd3, 16'd2});
        vecs.push_back('{16'd0, 16'h5555, CMD_OPT,  32'b0,   16'd0, 16'd0});
        vecs.push_back('{16'd2, 16'h0000, CMD_OUT,  32'b10,  16'd2, 16'd1});
        for (int i = 0; i < 4; i++) begin
            logic [15:0] it;
            logic [31:0] vd;
            logic [15:0] nc;
            it = 16'($urandom_range(1, 3));
            vd = $urandom;
            nc = '0;
            for (int j = 0; j < int'(it); j++) nc = nc + 16'(vd[j]);
            vecs.push_back('{it, ((i == 2) ? 16'h0 : 16'($urandom)), CMD_OPT, vd, it, nc});
        end
        foreach (vecs[i]) begin
            run_batch(int'(vecs[i].iter), vecs[i].seed, vecs[i].cmd, vecs[i].verd, pulses, commits);
            chk("vec_pulses", pulses, vecs[i].exp_pulses);
            chk("vec_commits", commits, vecs[i].exp_commits);
        end

        // seed whose draws include a zero, an out-of-range value and K==L
        found = 1'b0;
        fseed = 16'h0;
        for (int s = 1; s < 65536 && !found; s++) begin
            fd = model_draw(16'(s));
            if (fd.k == fd.l && fd.n_big != 0 && fd.n_zero != 0) begin
                found = 1'b1;
                fseed = 16'(s);
            end
        end
        for (int s = 1; s < 65536 && !found; s++) begin
            fd = model_draw(16'(s));
            if (fd.k == fd.l && fd.n_big != 0) begin
                found = 1'b1;
                fseed = 16'(s);
            end
        end
        chk("thr_seed_found", found, 1);
        if (found) begin
            run_batch(1, fseed, CMD_OPT, 32'b0, pulses, commits);
            chk("thr_command", opt_o.command, OPT_THR);
            chk("thr_k_eq_l", opt_o.K == opt_o.L, 1);
            chk("thr_no_commit", commits, 0);
        end

        // reset in the middle of a sweep
        start_i = 1'b1; iter_i = 16'd2; seed_i = 16'h0F0F; run_cmd_i = CMD_OPT;
        tick();
        start_i = 1'b0;
        cyc = 0;
        while (command_o == CMD_NOP && cyc < 400) begin
            tick();
            cyc++;
        end
        chk("midreset_pulse_seen", command_o, CMD_OPT);
        for (int i = 0; i < 6; i++) tick();
        reset = 1'b1;
        tick();
        chk("midreset_cmd", command_o, CMD_NOP);
        chk("midreset_opt", opt_o, {OPT_THR, 7'd0, 7'd0});
        chk("midreset_flags", {decide_o, commit_o, busy_o, done_o}, 4'b0000);
        reset = 1'b0;
        m_lfsr = 16'hACE1;
        tick();
        run_batch(1, 16'h0000, CMD_OPT, 32'b1, pulses, commits);
        chk("post_reset_pulses", pulses, 1);
        chk("post_reset_commits", commits, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
